// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the branch redirect controller.
// Opcode/funct3 encodings, FSM states and target select.
package brc_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        SQUASH
    } brc_state_t;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_BR,
        TGT_JAL,
        TGT_JALR
    } brc_tgt_t;

    // JALR targets ignore bit 0 of the computed address.
    function automatic logic [31:0] jalr_mask(input logic [31:0] t);
        return {t[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Redirect handshake from the branch unit to the PC/fetch logic.
// Master raises valid with a stable pc until ready is seen.
interface branch_redirect_ctrl_if;

    logic        BRC_redirect_valid;
    logic        BRC_redirect_ready;
    logic [31:0] BRC_redirect_pc;

    modport master (
        output BRC_redirect_valid,
        output BRC_redirect_pc,
        input  BRC_redirect_ready
    );

    modport slave (
        input  BRC_redirect_valid,
        input  BRC_redirect_pc,
        output BRC_redirect_ready
    );

endinterface

// File: rtl/branch_redirect_ctrl_cond.sv
// Combinational control-transfer decode for the EX instruction.
// Maps opcode/funct3/flags to taken, branch, illegal and target select.
module branch_cond_decode
    import brc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       br_eq,
    input  logic       br_lt,
    input  logic       br_ltu,
    output logic       taken,
    output logic       is_branch,
    output logic       illegal,
    output brc_tgt_t   target_sel
);

    logic is_br;
    logic is_jal;
    logic is_jalr;

    assign is_br   = (opcode == OP_BRANCH);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);

    // Resolve the condition and the target source for each opcode class.
    always_comb begin
        taken      = 1'b0;
        is_branch  = 1'b0;
        illegal    = 1'b0;
        target_sel = TGT_NONE;
        unique case (1'b1)
            is_br: begin
                is_branch  = 1'b1;
                target_sel = TGT_BR;
                case (funct3)
                    F3_BEQ:  taken = br_eq;
                    F3_BNE:  taken = ~br_eq;
                    F3_BLT:  taken = br_lt;
                    F3_BGE:  taken = ~br_lt;
                    F3_BLTU: taken = br_ltu;
                    F3_BGEU: taken = ~br_ltu;
                    default: illegal = 1'b1;
                endcase
            end
            is_jal: begin
                taken      = 1'b1;
                target_sel = TGT_JAL;
            end
            is_jalr: begin
                taken      = 1'b1;
                target_sel = TGT_JALR;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution, PC redirect handshake and squash window.
// Fetch predicts not-taken, so every taken transfer redirects.
module branch_redirect_ctrl
    import brc_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 BRC_ex_valid,
    input  logic                 BRC_stall,
    input  logic [6:0]           BRC_opcode,
    input  logic [2:0]           BRC_funct3,
    input  logic                 BRC_br_eq,
    input  logic                 BRC_br_lt,
    input  logic                 BRC_br_ltu,
    input  logic [31:0]          BRC_br_target,
    input  logic [31:0]          BRC_jal_target,
    input  logic [31:0]          BRC_jalr_target,
    branch_redirect_ctrl_if.master redir,
    output logic                 BRC_flush,
    output logic                 BRC_misalign_err,
    output logic                 BRC_illegal_br,
    output logic [CNT_W-1:0]     BRC_branch_cnt,
    output logic [CNT_W-1:0]     BRC_taken_cnt
);

    localparam logic [3:0]       SQ_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    brc_state_t  state;
    logic [3:0]  sq_cnt;
    logic        eval;
    logic        taken;
    logic        is_branch;
    logic        illegal;
    brc_tgt_t    target_sel;
    logic [31:0] target;
    logic        misaligned;
    logic        do_redirect;

    branch_cond_decode u_decode (
        .opcode     (BRC_opcode),
        .funct3     (BRC_funct3),
        .br_eq      (BRC_br_eq),
        .br_lt      (BRC_br_lt),
        .br_ltu     (BRC_br_ltu),
        .taken      (taken),
        .is_branch  (is_branch),
        .illegal    (illegal),
        .target_sel (target_sel)
    );

    assign eval = BRC_ex_valid & ~BRC_stall & (state == IDLE);

    // Pick the redirect target for the decoded transfer type.
    always_comb begin
        target = 32'h0;
        unique case (target_sel)
            TGT_BR:   target = BRC_br_target;
            TGT_JAL:  target = BRC_jal_target;
            TGT_JALR: target = jalr_mask(BRC_jalr_target);
            default:  target = 32'h0;
        endcase
    end

    assign misaligned  = taken & target[1];
    assign do_redirect = eval & taken & ~target[1];

    // Redirect FSM with registered handshake, flush and error pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state                    <= IDLE;
            sq_cnt                   <= 4'd0;
            redir.BRC_redirect_valid <= 1'b0;
            redir.BRC_redirect_pc    <= 32'h0;
            BRC_flush                <= 1'b0;
            BRC_misalign_err         <= 1'b0;
            BRC_illegal_br           <= 1'b0;
        end else begin
            BRC_misalign_err <= 1'b0;
            BRC_illegal_br   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (eval) begin
                        BRC_illegal_br   <= is_branch & illegal;
                        BRC_misalign_err <= misaligned;
                    end
                    if (do_redirect) begin
                        state                    <= REDIRECT;
                        redir.BRC_redirect_valid <= 1'b1;
                        redir.BRC_redirect_pc    <= target;
                        BRC_flush                <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (redir.BRC_redirect_ready) begin
                        state                    <= SQUASH;
                        redir.BRC_redirect_valid <= 1'b0;
                        sq_cnt                   <= SQ_LOAD;
                    end
                end
                SQUASH: begin
                    if (sq_cnt == 4'd0) begin
                        state     <= IDLE;
                        BRC_flush <= 1'b0;
                    end else begin
                        sq_cnt <= sq_cnt - 4'd1;
                    end
                end
                default: begin
                    state                    <= IDLE;
                    redir.BRC_redirect_valid <= 1'b0;
                    BRC_flush                <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics, updated in the evaluation cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BRC_branch_cnt <= '0;
            BRC_taken_cnt  <= '0;
        end else begin
            if (eval && is_branch && BRC_branch_cnt != CNT_MAX)
                BRC_branch_cnt <= BRC_branch_cnt + CNT_ONE;
            if (do_redirect && BRC_taken_cnt != CNT_MAX)
                BRC_taken_cnt <= BRC_taken_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with a redirect scoreboard.
// Expected targets are queued at issue and checked on each handshake.
module tb_branch_redirect_ctrl;
    import brc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        stall;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        br_eq;
    logic        br_lt;
    logic        br_ltu;
    logic [31:0] br_target;
    logic [31:0] jal_target;
    logic [31:0] jalr_target;
    logic        flush;
    logic        misalign_err;
    logic        illegal_br;
    logic [3:0]  branch_cnt;
    logic [3:0]  taken_cnt;

    int checks;
    int failures;
    int flush_n;
    int guard;
    logic [31:0] exp_q[$];

    branch_redirect_ctrl_if rif ();

    branch_redirect_ctrl #(
        .FLUSH_CYCLES (2),
        .CNT_W        (4)
    ) dut (
        .CLK             (clk),
        .RST_N           (rst_n),
        .BRC_ex_valid    (ex_valid),
        .BRC_stall       (stall),
        .BRC_opcode      (opcode),
        .BRC_funct3      (funct3),
        .BRC_br_eq       (br_eq),
        .BRC_br_lt       (br_lt),
        .BRC_br_ltu      (br_ltu),
        .BRC_br_target   (br_target),
        .BRC_jal_target  (jal_target),
        .BRC_jalr_target (jalr_target),
        .redir           (rif.master),
        .BRC_flush       (flush),
        .BRC_misalign_err(misalign_err),
        .BRC_illegal_br  (illegal_br),
        .BRC_branch_cnt  (branch_cnt),
        .BRC_taken_cnt   (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [6:0] op, input logic [2:0] f3,
                         input logic eq, input logic lt, input logic ltu,
                         input logic [31:0] bt, input logic [31:0] jt,
                         input logic [31:0] jrt);
        opcode      = op;
        funct3      = f3;
        br_eq       = eq;
        br_lt       = lt;
        br_ltu      = ltu;
        br_target   = bt;
        jal_target  = jt;
        jalr_target = jrt;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic eq, input logic lt, input logic ltu,
                         input logic [31:0] bt, input logic [31:0] jt,
                         input logic [31:0] jrt);
        setup(op, f3, eq, lt, ltu, bt, jt, jrt);
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
    endtask

    task automatic wait_idle();
        guard = 0;
        while (flush && guard < 30) begin
            step();
            guard++;
        end
        chk("flush_timeout", 32'(guard < 30), 32'd1);
    endtask

    // Scoreboard: every accepted redirect must match the oldest queued pc.
    always @(negedge clk) begin
        if (rst_n && rif.BRC_redirect_valid && rif.BRC_redirect_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", rif.BRC_redirect_pc, 32'hdead_beef);
            end else begin
                chk("sb_pc", rif.BRC_redirect_pc, exp_q.pop_front());
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        stall    = 1'b0;
        rif.BRC_redirect_ready = 1'b1;
        setup(7'h0, 3'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        #12;
        chk("rst_valid", 32'(rif.BRC_redirect_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_bcnt", 32'(branch_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // BEQ taken, ready high
        exp_q.push_back(32'h100);
        issue(OP_BRANCH, F3_BEQ, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0);
        chk("beq_valid", 32'(rif.BRC_redirect_valid), 32'd1);
        chk("beq_pc", rif.BRC_redirect_pc, 32'h100);
        chk("beq_bcnt", 32'(branch_cnt), 32'd1);
        chk("beq_tcnt", 32'(taken_cnt), 32'd1);
        flush_n = 0;
        guard   = 0;
        while (flush && guard < 30) begin
            flush_n++;
            guard++;
            step();
            if (flush_n == 1)
                chk("beq_valid_drop", 32'(rif.BRC_redirect_valid), 32'd0);
        end
        chk("beq_flush_len", 32'(flush_n), 32'd3);

        // BGE with lt=1: not taken
        issue(OP_BRANCH, F3_BGE, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h0);
        chk("bge_valid", 32'(rif.BRC_redirect_valid), 32'd0);
        chk("bge_flush", 32'(flush), 32'd0);
        chk("bge_bcnt", 32'(branch_cnt), 32'd2);
        chk("bge_tcnt", 32'(taken_cnt), 32'd1);

        // Non-control opcode leaves counters alone
        issue(7'b0110011, 3'b000, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
        chk("alu_bcnt", 32'(branch_cnt), 32'd2);
        chk("alu_valid", 32'(rif.BRC_redirect_valid), 32'd0);

        // JALR misaligned after bit0 mask
        issue(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2003);
        chk("jalr_mis_err", 32'(misalign_err), 32'd1);
        chk("jalr_mis_valid", 32'(rif.BRC_redirect_valid), 32'd0);
        chk("jalr_mis_tcnt", 32'(taken_cnt), 32'd1);
        step();
        chk("jalr_mis_pulse", 32'(misalign_err), 32'd0);

        // JALR aligned after mask
        exp_q.push_back(32'h2000);
        issue(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2001);
        chk("jalr_pc", rif.BRC_redirect_pc, 32'h2000);
        chk("jalr_tcnt", 32'(taken_cnt), 32'd2);
        wait_idle();

        // JAL with ready held low, wrong-path traffic ignored
        rif.BRC_redirect_ready = 1'b0;
        exp_q.push_back(32'h400);
        issue(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h400, 32'h0);
        setup(OP_BRANCH, F3_BEQ, 1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 32'h0);
        ex_valid = 1'b1;
        flush_n  = 0;
        for (int i = 0; i < 5; i++) begin
            chk("jal_hold_valid", 32'(rif.BRC_redirect_valid), 32'd1);
            chk("jal_hold_pc", rif.BRC_redirect_pc, 32'h400);
            if (flush) flush_n++;
            if (i == 4) begin
                rif.BRC_redirect_ready = 1'b1;
                ex_valid = 1'b0;
            end
            step();
        end
        guard = 0;
        while (flush && guard < 30) begin
            flush_n++;
            guard++;
            step();
        end
        chk("jal_flush_len", 32'(flush_n), 32'd7);
        chk("jal_bcnt", 32'(branch_cnt), 32'd2);
        chk("jal_tcnt", 32'(taken_cnt), 32'd3);

        // BLTU held by stall for 3 cycles
        setup(OP_BRANCH, F3_BLTU, 1'b0, 1'b0, 1'b1, 32'h800, 32'h0, 32'h0);
        ex_valid = 1'b1;
        stall    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(rif.BRC_redirect_valid), 32'd0);
            chk("stall_bcnt", 32'(branch_cnt), 32'd2);
        end
        stall = 1'b0;
        exp_q.push_back(32'h800);
        step();
        ex_valid = 1'b0;
        chk("bltu_valid", 32'(rif.BRC_redirect_valid), 32'd1);
        chk("bltu_bcnt", 32'(branch_cnt), 32'd3);
        chk("bltu_tcnt", 32'(taken_cnt), 32'd4);
        wait_idle();

        // Reserved funct3 010
        issue(OP_BRANCH, 3'b010, 1'b1, 1'b1, 1'b1, 32'h300, 32'h0, 32'h0);
        chk("ill_pulse", 32'(illegal_br), 32'd1);
        chk("ill_valid", 32'(rif.BRC_redirect_valid), 32'd0);
        chk("ill_bcnt", 32'(branch_cnt), 32'd4);
        step();
        chk("ill_pulse_end", 32'(illegal_br), 32'd0);

        // Async reset during REDIRECT drops the request
        rif.BRC_redirect_ready = 1'b0;
        issue(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40, 32'h0);
        chk("pre_rst_valid", 32'(rif.BRC_redirect_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(rif.BRC_redirect_valid), 32'd0);
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_pc", rif.BRC_redirect_pc, 32'h0);
        chk("arst_tcnt", 32'(taken_cnt), 32'd0);
        chk("arst_bcnt", 32'(branch_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        rif.BRC_redirect_ready = 1'b1;
        step();
        exp_q.push_back(32'h80);
        issue(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80, 32'h0);
        chk("post_rst_valid", 32'(rif.BRC_redirect_valid), 32'd1);
        chk("post_rst_tcnt", 32'(taken_cnt), 32'd1);
        wait_idle();

        // Saturation of the 4-bit taken counter
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(32'h100 + 32'(i * 4));
            issue(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0,
                  32'h0, 32'h100 + 32'(i * 4), 32'h0);
            wait_idle();
        end
        chk("sat_tcnt", 32'(taken_cnt), 32'd15);
        chk("sat_bcnt", 32'(branch_cnt), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
